// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and defaults for the UART receive FIFO.
package uart_rx_fifo_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned ENTRY_W     = UART_DATA_W + 1;

    localparam int unsigned DEF_DEPTH     = 16;
    localparam int unsigned DEF_HIGH_MARK = 12;
    localparam int unsigned DEF_LOW_MARK  = 4;

    typedef struct packed {
        logic                   err;
        logic [UART_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and register-side signals of the UART receive FIFO.
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned AW = 4
);
    logic [UART_DATA_W-1:0] rx_data;
    logic                   rx_ready;
    logic                   rx_error;
    logic                   handshake;
    logic                   rd_en;
    logic                   clr_ovf;
    logic [UART_DATA_W-1:0] rd_data;
    logic                   rd_err;
    logic                   empty;
    logic                   full;
    logic [AW:0]            count;
    logic                   overflow;
    logic                   rts_n;

    modport master (
        output rx_data, rx_ready, rx_error, handshake, rd_en, clr_ovf,
        input  rd_data, rd_err, empty, full, count, overflow, rts_n
    );

    modport slave (
        input  rx_data, rx_ready, rx_error, handshake, rd_en, clr_ovf,
        output rd_data, rd_err, empty, full, count, overflow, rts_n
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x {err, data} register array: synchronous write, asynchronous read.
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fifo_entry_t   wdata,
    input  logic [AW-1:0] raddr,
    output fifo_entry_t   rdata
);
    fifo_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures bytes and error events, presents them FWFT,
// and throttles the remote transmitter through RTS with hysteresis.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AW        = $clog2(DEPTH),
    parameter int unsigned HIGH_MARK = DEF_HIGH_MARK,
    parameter int unsigned LOW_MARK  = DEF_LOW_MARK
) (
    input logic          clk,
    input logic          rst,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, full_q;
    logic          ovf_q, ovf_d;
    logic          rts_n_q, rts_n_d;
    logic          err_q;

    logic          err_rise, push, pop, push_ok, drop;
    fifo_entry_t   wr_entry, head;

    // A held error level yields only one error entry.
    assign err_rise = bus.rx_error & ~err_q;
    assign push     = bus.rx_ready | err_rise;
    assign pop      = bus.rd_en & ~empty_q;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign push_ok  = push & (~full_q | pop);
    assign drop     = push & full_q & ~pop;

    assign wr_entry.err  = err_rise;
    assign wr_entry.data = bus.rx_data;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Hysteresis on the next-state count; between the marks RTS holds.
    always_comb begin
        rts_n_d = rts_n_q;
        if (!bus.handshake) begin
            rts_n_d = 1'b0;
        end else if (count_d >= CW'(HIGH_MARK)) begin
            rts_n_d = 1'b1;
        end else if (count_d <= CW'(LOW_MARK)) begin
            rts_n_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rts_n_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == CW'(DEPTH));
            ovf_q    <= ovf_d;
            rts_n_q  <= rts_n_d;
            err_q    <= bus.rx_error;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    assign bus.rd_data  = head.data;
    assign bus.rd_err   = head.err;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
    assign bus.rts_n    = rts_n_q;
endmodule
